// File: rtl/infix_pkg.sv
// -----------------------------------------------------------------------------
// infix_pkg
// Shared definitions for the infix-to-postfix converter: ASCII token codes for
// the operators and parentheses, the controller state encoding, and helpers
// that classify operators and give their precedence.
// No ports (package).
// -----------------------------------------------------------------------------
package infix_pkg;

  localparam logic [7:0] SIGN_ADD = 8'h2B;  // "+"
  localparam logic [7:0] SIGN_SUB = 8'h2D;  // "-"
  localparam logic [7:0] SIGN_MUL = 8'h2A;  // "*"
  localparam logic [7:0] SIGN_DIV = 8'h2F;  // "/"
  localparam logic [7:0] SIGN_LP  = 8'h28;  // "("
  localparam logic [7:0] SIGN_RP  = 8'h29;  // ")"

  typedef enum logic [2:0] {
    ACCEPT    = 3'd0,
    POP_OPS   = 3'd1,
    GAP       = 3'd2,
    POP_PAREN = 3'd3,
    FLUSH     = 3'd4,
    END_MARK  = 3'd5,
    HALT      = 3'd6
  } state_t;

  // "(" and anything unknown rank 0, so an open paren on the stack is never
  // popped by an incoming operator.
  function automatic logic [1:0] prec(input logic [7:0] sign);
    logic [1:0] p;
    case (sign)
      SIGN_MUL, SIGN_DIV: p = 2'd2;
      SIGN_ADD, SIGN_SUB: p = 2'd1;
      default:            p = 2'd0;
    endcase
    return p;
  endfunction

  function automatic logic is_op(input logic [7:0] sign);
    logic r;
    case (sign)
      SIGN_ADD, SIGN_SUB, SIGN_MUL, SIGN_DIV: r = 1'b1;
      default:                                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/infix_to_postfix_op_stack.sv
// -----------------------------------------------------------------------------
// op_stack
// Synchronous LIFO of 8-bit operator codes used by the shunting-yard
// controller. Push and pop in the same cycle replace the top entry.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   push, pop, din  stack operations and data to push
//   top             current top entry (0 when empty)
//   full, empty     occupancy flags
//   count           number of entries, PTR_W wide so full != empty
// -----------------------------------------------------------------------------
module op_stack
  import infix_pkg::*;
#(
  parameter  int STACK_DEPTH = 16,
  localparam int PTR_W       = $clog2(STACK_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       din,
  output logic [7:0]       top,
  output logic             full,
  output logic             empty,
  output logic [PTR_W-1:0] count
);

  localparam int IDX_W = PTR_W - 1;

  logic [7:0]       mem_r [STACK_DEPTH];
  logic [PTR_W-1:0] count_r;
  logic [IDX_W-1:0] top_idx_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty = (count_r == {PTR_W{1'b0}});
  assign full  = (count_r == PTR_W'(STACK_DEPTH));
  assign count = count_r;

  // A full count truncates to index 0, so top_idx wraps to the last slot.
  assign top_idx_s = count_r[IDX_W-1:0] - IDX_W'(1'b1);
  assign do_pop_s  = pop & ~empty;
  // Push on a full stack is only legal as a replace (paired with a pop).
  assign do_push_s = push & (~full | do_pop_s);
  assign wr_idx_s  = do_pop_s ? top_idx_s : count_r[IDX_W-1:0];
  assign top       = empty ? 8'h00 : mem_r[top_idx_s];

  // Occupancy counter; a replace leaves it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {PTR_W{1'b0}};
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + PTR_W'(1'b1);
        2'b01:   count_r <= count_r - PTR_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care above count so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_idx_s] <= din;
    end
  end

endmodule

// File: rtl/infix_to_postfix.sv
// -----------------------------------------------------------------------------
// infix_to_postfix
// Shunting-yard converter: turns an infix token stream (8-bit numbers, + - * /,
// parentheses) into a postfix stream for the downstream evaluator. Every
// emitted operator is followed by one idle (GAP) cycle. An expression ends
// with a marker cycle carrying both strobes and zero values.
// Optional build macro INFIX_DEPTH_MON_EN adds MAX_DEPTH, the stack
// high-water mark since reset.
// Ports:
//   CLK, RST                   clock, asynchronous active-high reset
//   IN_NUMBER/IN_NUMBER_STB    number token
//   IN_SIGN/IN_SIGN_STB        ASCII operator or parenthesis token
//   IN_END_STB                 end of expression
//   BUSY                       high while tokens cannot be accepted
//   OUT_NUMBER/NUMBER_STB      postfix number
//   OUT_SIGN/SIGN_STB          postfix operator
//   MAX_DEPTH                  (INFIX_DEPTH_MON_EN only) stack high-water mark
//   ERR                        sticky error flag
// -----------------------------------------------------------------------------
module infix_to_postfix
  import infix_pkg::*;
#(
  parameter  int STACK_DEPTH = 16,
  localparam int PTR_W       = $clog2(STACK_DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       IN_NUMBER,
  input  logic             IN_NUMBER_STB,
  input  logic [7:0]       IN_SIGN,
  input  logic             IN_SIGN_STB,
  input  logic             IN_END_STB,
  output logic             BUSY,
  output logic [7:0]       OUT_NUMBER,
  output logic             NUMBER_STB,
  output logic [7:0]       OUT_SIGN,
  output logic             SIGN_STB,
`ifdef INFIX_DEPTH_MON_EN
  output logic [PTR_W-1:0] MAX_DEPTH,
`endif
  output logic             ERR
);

  state_t           state_r;
  state_t           ret_r;       // state to resume after a GAP cycle
  logic [7:0]       pend_r;      // incoming operator waiting to be pushed
  logic             busy_r;
  logic [7:0]       num_r;
  logic             num_stb_r;
  logic [7:0]       sign_r;
  logic             sign_stb_r;
  logic             err_r;

  logic             push_s;
  logic             pop_s;
  logic [7:0]       din_s;
  logic [7:0]       top_s;
  logic             full_s;
  logic             empty_s;
  logic [PTR_W-1:0] stk_count_s;

  logic [1:0]       n_stb_s;
  logic             take_s;
  logic             multi_s;
  logic             lp_in_s;
  logic             emit_ops_s;
  logic             stk_ok_s;

  op_stack #(.STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk   (CLK),
    .rst   (RST),
    .push  (push_s),
    .pop   (pop_s),
    .din   (din_s),
    .top   (top_s),
    .full  (full_s),
    .empty (empty_s),
    .count (stk_count_s)
  );

  assign n_stb_s    = {1'b0, IN_NUMBER_STB} + {1'b0, IN_SIGN_STB} + {1'b0, IN_END_STB};
  assign take_s     = (state_r == ACCEPT) && (n_stb_s == 2'd1);
  assign multi_s    = (state_r == ACCEPT) && (n_stb_s > 2'd1);
  assign lp_in_s    = take_s && IN_SIGN_STB && (IN_SIGN == SIGN_LP);
  // Left associativity: equal precedence on top is popped before the push.
  assign emit_ops_s = !empty_s && (prec(top_s) >= prec(pend_r));
  // Flags must agree with the count; a disagreement means corrupted state.
  assign stk_ok_s   = (empty_s == (stk_count_s == {PTR_W{1'b0}})) &&
                      (full_s  == (stk_count_s == PTR_W'(STACK_DEPTH)));

  // Stack push/pop requests derived from the current state and token.
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    din_s  = 8'h00;
    case (state_r)
      ACCEPT: begin
        if (lp_in_s && !full_s) begin
          push_s = 1'b1;
          din_s  = SIGN_LP;
        end else begin
          push_s = 1'b0;
        end
      end
      POP_OPS: begin
        if (emit_ops_s) begin
          pop_s = 1'b1;
        end else if (!full_s) begin
          push_s = 1'b1;
          din_s  = pend_r;
        end else begin
          push_s = 1'b0;
        end
      end
      POP_PAREN: begin
        if (!empty_s) begin
          pop_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
      end
      FLUSH: begin
        if (!empty_s && (top_s != SIGN_LP)) begin
          pop_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
      end
      default: begin
        pop_s = 1'b0;
      end
    endcase
  end

  // Controller FSM with registered BUSY, ERR and output strobes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r    <= ACCEPT;
      ret_r      <= ACCEPT;
      pend_r     <= 8'h00;
      busy_r     <= 1'b0;
      num_r      <= 8'h00;
      num_stb_r  <= 1'b0;
      sign_r     <= 8'h00;
      sign_stb_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      num_stb_r  <= 1'b0;
      sign_stb_r <= 1'b0;
      num_r      <= 8'h00;
      sign_r     <= 8'h00;
      if (!stk_ok_s) begin
        state_r <= HALT;
        busy_r  <= 1'b1;
        err_r   <= 1'b1;
      end else begin
        case (state_r)
          ACCEPT: begin
            if (multi_s) begin
              err_r <= 1'b1;
            end else if (take_s) begin
              if (IN_NUMBER_STB) begin
                num_stb_r <= 1'b1;
                num_r     <= IN_NUMBER;
              end else if (IN_END_STB) begin
                state_r <= FLUSH;
                busy_r  <= 1'b1;
              end else if (IN_SIGN == SIGN_LP) begin
                if (full_s) begin
                  state_r <= HALT;
                  busy_r  <= 1'b1;
                  err_r   <= 1'b1;
                end else begin
                  state_r <= ACCEPT;
                end
              end else if (IN_SIGN == SIGN_RP) begin
                state_r <= POP_PAREN;
                busy_r  <= 1'b1;
              end else if (is_op(IN_SIGN)) begin
                pend_r  <= IN_SIGN;
                state_r <= POP_OPS;
                busy_r  <= 1'b1;
              end else begin
                state_r <= HALT;
                busy_r  <= 1'b1;
                err_r   <= 1'b1;
              end
            end else begin
              state_r <= ACCEPT;
            end
          end
          POP_OPS: begin
            if (emit_ops_s) begin
              sign_stb_r <= 1'b1;
              sign_r     <= top_s;
              ret_r      <= POP_OPS;
              state_r    <= GAP;
            end else if (full_s) begin
              state_r <= HALT;
              err_r   <= 1'b1;
            end else begin
              state_r <= ACCEPT;
              busy_r  <= 1'b0;
            end
          end
          GAP: begin
            state_r <= ret_r;
          end
          POP_PAREN: begin
            if (empty_s) begin
              state_r <= HALT;
              err_r   <= 1'b1;
            end else if (top_s == SIGN_LP) begin
              state_r <= ACCEPT;
              busy_r  <= 1'b0;
            end else begin
              sign_stb_r <= 1'b1;
              sign_r     <= top_s;
              ret_r      <= POP_PAREN;
              state_r    <= GAP;
            end
          end
          FLUSH: begin
            if (empty_s) begin
              // End marker strobes are visible during the END_MARK cycle.
              num_stb_r  <= 1'b1;
              sign_stb_r <= 1'b1;
              state_r    <= END_MARK;
            end else if (top_s == SIGN_LP) begin
              state_r <= HALT;
              err_r   <= 1'b1;
            end else begin
              sign_stb_r <= 1'b1;
              sign_r     <= top_s;
              ret_r      <= FLUSH;
              state_r    <= GAP;
            end
          end
          END_MARK: begin
            state_r <= ACCEPT;
            busy_r  <= 1'b0;
          end
          HALT: begin
            busy_r <= 1'b1;
            err_r  <= 1'b1;
          end
          default: begin
            state_r <= HALT;
            busy_r  <= 1'b1;
            err_r   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign BUSY       = busy_r;
  assign OUT_NUMBER = num_r;
  assign NUMBER_STB = num_stb_r;
  assign OUT_SIGN   = sign_r;
  assign SIGN_STB   = sign_stb_r;
  assign ERR        = err_r;

`ifdef INFIX_DEPTH_MON_EN
  logic [PTR_W-1:0] max_depth_r;

  // High-water mark of stack occupancy; only reset clears it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      max_depth_r <= {PTR_W{1'b0}};
    end else if (stk_count_s > max_depth_r) begin
      max_depth_r <= stk_count_s;
    end else begin
      max_depth_r <= max_depth_r;
    end
  end

  assign MAX_DEPTH = max_depth_r;
`endif

endmodule

// File: tb/tb_infix_to_postfix.sv
// -----------------------------------------------------------------------------
// tb_infix_to_postfix
// Directed bench: a behavioural shunting-yard model predicts the postfix
// stream as tokens are driven; a negedge monitor pops and compares each
// emitted token and checks the idle cycle after every operator.
// -----------------------------------------------------------------------------
module tb_infix_to_postfix;

  localparam int STACK_DEPTH = 16;
  localparam int PTR_W       = $clog2(STACK_DEPTH) + 1;

  localparam logic [7:0] C_ADD = 8'h2B;
  localparam logic [7:0] C_SUB = 8'h2D;
  localparam logic [7:0] C_MUL = 8'h2A;
  localparam logic [7:0] C_DIV = 8'h2F;
  localparam logic [7:0] C_LP  = 8'h28;
  localparam logic [7:0] C_RP  = 8'h29;

  localparam logic [1:0] K_NUM  = 2'd1;
  localparam logic [1:0] K_SIGN = 2'd2;
  localparam logic [1:0] K_END  = 2'd3;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] IN_NUMBER = 8'h00;
  logic       IN_NUMBER_STB = 1'b0;
  logic [7:0] IN_SIGN = 8'h00;
  logic       IN_SIGN_STB = 1'b0;
  logic       IN_END_STB = 1'b0;
  logic       BUSY;
  logic [7:0] OUT_NUMBER;
  logic       NUMBER_STB;
  logic [7:0] OUT_SIGN;
  logic       SIGN_STB;
  logic       ERR;
`ifdef INFIX_DEPTH_MON_EN
  logic [PTR_W-1:0] MAX_DEPTH;
`endif

  infix_to_postfix #(.STACK_DEPTH(STACK_DEPTH)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .IN_NUMBER     (IN_NUMBER),
    .IN_NUMBER_STB (IN_NUMBER_STB),
    .IN_SIGN       (IN_SIGN),
    .IN_SIGN_STB   (IN_SIGN_STB),
    .IN_END_STB    (IN_END_STB),
    .BUSY          (BUSY),
    .OUT_NUMBER    (OUT_NUMBER),
    .NUMBER_STB    (NUMBER_STB),
    .OUT_SIGN      (OUT_SIGN),
    .SIGN_STB      (SIGN_STB),
`ifdef INFIX_DEPTH_MON_EN
    .MAX_DEPTH     (MAX_DEPTH),
`endif
    .ERR           (ERR)
  );

  always #5 CLK = ~CLK;

  int          vectors     = 0;
  int          miscompares = 0;
  int          seen        = 0;
  logic        prev_sign   = 1'b0;
  logic [17:0] exp_q [$];
  logic [7:0]  mstk  [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [1:0] mprec(input logic [7:0] s);
    if (s == C_MUL || s == C_DIV) return 2'd2;
    else if (s == C_ADD || s == C_SUB) return 2'd1;
    else return 2'd0;
  endfunction

  // Output monitor: compare each emitted token and the gap after operators.
  always @(negedge CLK) begin
    logic [17:0] obs;
    logic [17:0] expv;
    if (prev_sign) check("gap_after_sign", 32'({NUMBER_STB, SIGN_STB}), 32'd0);
    prev_sign <= SIGN_STB & ~NUMBER_STB;
    if (NUMBER_STB || SIGN_STB) begin
      obs = {SIGN_STB, NUMBER_STB,
             (NUMBER_STB ? OUT_NUMBER : 8'h00), (SIGN_STB ? OUT_SIGN : 8'h00)};
      check("token_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        expv = exp_q.pop_front();
        check("token", 32'(obs), 32'(expv));
      end
      seen <= seen + 1;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (BUSY !== 1'b0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("ready_before_drive", 32'(BUSY), 32'd0);
  endtask

  task automatic send_num(input logic [7:0] v);
    wait_ready();
    exp_q.push_back({K_NUM, v, 8'h00});
    IN_NUMBER = v;
    IN_NUMBER_STB = 1'b1;
    @(negedge CLK);
    IN_NUMBER_STB = 1'b0;
  endtask

  task automatic send_sign(input logic [7:0] s);
    wait_ready();
    if (s == C_LP) begin
      mstk.push_back(s);
    end else if (s == C_RP) begin
      while (mstk.size() > 0 && mstk[$] != C_LP) exp_q.push_back({K_SIGN, 8'h00, mstk.pop_back()});
      if (mstk.size() > 0) void'(mstk.pop_back());
    end else begin
      while (mstk.size() > 0 && mprec(mstk[$]) >= mprec(s)) exp_q.push_back({K_SIGN, 8'h00, mstk.pop_back()});
      mstk.push_back(s);
    end
    IN_SIGN = s;
    IN_SIGN_STB = 1'b1;
    @(negedge CLK);
    IN_SIGN_STB = 1'b0;
  endtask

  task automatic send_end();
    wait_ready();
    while (mstk.size() > 0 && mstk[$] != C_LP) exp_q.push_back({K_SIGN, 8'h00, mstk.pop_back()});
    if (mstk.size() == 0) exp_q.push_back({K_END, 8'h00, 8'h00});
    IN_END_STB = 1'b1;
    @(negedge CLK);
    IN_END_STB = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || BUSY !== 1'b0) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    repeat (2) @(negedge CLK);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    exp_q.delete();
    mstk.delete();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cycles;
    int seen0;
    int n;

    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_strobes", 32'({NUMBER_STB, SIGN_STB}), 32'd0);
    check("rst_values", 32'({OUT_NUMBER, OUT_SIGN}), 32'd0);
    check("rst_sp", 32'(dut.stk_count_s), 32'd0);
`ifdef INFIX_DEPTH_MON_EN
    check("rst_max_depth", 32'(MAX_DEPTH), 32'd0);
`endif

    // 3 + 4 * 2
    send_num(8'd3); send_sign(C_ADD); send_num(8'd4); send_sign(C_MUL); send_num(8'd2); send_end();
    wait_idle("expr1_drained");
    check("expr1_err", 32'(ERR), 32'd0);

    // ( 1 + 2 ) * 3
    send_sign(C_LP); send_num(8'd1); send_sign(C_ADD); send_num(8'd2); send_sign(C_RP);
    send_sign(C_MUL); send_num(8'd3); send_end();
    wait_idle("expr2_drained");
    check("expr2_sp_empty", 32'(dut.stk_count_s), 32'd0);

    // 8 - 3 - 2 with busy length after the second "-"
    send_num(8'd8); send_sign(C_SUB); send_num(8'd3); send_sign(C_SUB);
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (BUSY === 1'b1) busy_cycles++;
      else break;
      @(negedge CLK);
    end
    check("expr3_busy_cycles", 32'(busy_cycles), 32'd3);
    send_num(8'd2); send_end();
    wait_idle("expr3_drained");

    // 9 / ( 4 - 1 ) * 2 + 7
    send_num(8'd9); send_sign(C_DIV); send_sign(C_LP); send_num(8'd4); send_sign(C_SUB);
    send_num(8'd1); send_sign(C_RP); send_sign(C_MUL); send_num(8'd2); send_sign(C_ADD);
    send_num(8'd7); send_end();
    wait_idle("expr4_drained");
    check("expr4_err", 32'(ERR), 32'd0);
`ifdef INFIX_DEPTH_MON_EN
    check("expr4_max_depth", 32'(MAX_DEPTH), 32'd3);
`endif

    // two strobes together: ERR set, token ignored, still accepting
    wait_ready();
    IN_NUMBER = 8'd55; IN_SIGN = C_ADD; IN_NUMBER_STB = 1'b1; IN_SIGN_STB = 1'b1;
    @(negedge CLK);
    IN_NUMBER_STB = 1'b0; IN_SIGN_STB = 1'b0;
    repeat (3) @(negedge CLK);
    check("multi_err", 32'(ERR), 32'd1);
    check("multi_busy", 32'(BUSY), 32'd0);
    do_reset();
    check("multi_rst_err", 32'(ERR), 32'd0);

    // 17 open parens overflow a 16-entry stack
    for (int i = 0; i < STACK_DEPTH; i++) send_sign(C_LP);
    check("ovf_err_before", 32'(ERR), 32'd0);
    wait_ready();
    IN_SIGN = C_LP; IN_SIGN_STB = 1'b1;
    @(negedge CLK);
    IN_SIGN_STB = 1'b0;
    check("ovf_err", 32'(ERR), 32'd1);
    check("ovf_busy", 32'(BUSY), 32'd1);
    IN_NUMBER = 8'd9; IN_NUMBER_STB = 1'b1;
    @(negedge CLK);
    IN_NUMBER_STB = 1'b0;
    IN_END_STB = 1'b1;
    @(negedge CLK);
    IN_END_STB = 1'b0;
    repeat (5) @(negedge CLK);
    check("ovf_busy_held", 32'(BUSY), 32'd1);
    check("ovf_err_held", 32'(ERR), 32'd1);
`ifdef INFIX_DEPTH_MON_EN
    check("ovf_max_depth", 32'(MAX_DEPTH), 32'(STACK_DEPTH));
`endif
    do_reset();
    check("ovf_rst_err", 32'(ERR), 32'd0);
    check("ovf_rst_busy", 32'(BUSY), 32'd0);
`ifdef INFIX_DEPTH_MON_EN
    check("ovf_rst_max_depth", 32'(MAX_DEPTH), 32'd0);
`endif

    // 5 ) : unmatched close paren
    send_num(8'd5); send_sign(C_RP);
    repeat (3) @(negedge CLK);
    check("rp_err", 32'(ERR), 32'd1);
    check("rp_busy", 32'(BUSY), 32'd1);
    do_reset();
    check("rp_rst_err", 32'(ERR), 32'd0);
    check("rp_rst_busy", 32'(BUSY), 32'd0);
    send_num(8'd2); send_sign(C_MUL); send_num(8'd2); send_end();
    wait_idle("rp_recover_drained");

    // ( 5 END : unmatched open paren
    send_sign(C_LP); send_num(8'd5); send_end();
    repeat (3) @(negedge CLK);
    check("lp_err", 32'(ERR), 32'd1);
    check("lp_busy", 32'(BUSY), 32'd1);
    do_reset();
    check("lp_rst_err", 32'(ERR), 32'd0);
    send_num(8'd2); send_sign(C_MUL); send_num(8'd2); send_end();
    wait_idle("lp_recover_drained");

    // async reset during FLUSH of 1 + 2 * 3, right after "*" is emitted
    seen0 = seen;
    send_num(8'd1); send_sign(C_ADD); send_num(8'd2); send_sign(C_MUL); send_num(8'd3); send_end();
    n = 0;
    while ((seen - seen0) < 4 && n < 100) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check("flush_reached", 32'(seen - seen0), 32'd4);
    RST = 1'b1;
    #1;
    check("async_strobes", 32'({NUMBER_STB, SIGN_STB}), 32'd0);
    check("async_values", 32'({OUT_NUMBER, OUT_SIGN}), 32'd0);
    check("async_busy", 32'(BUSY), 32'd0);
    check("async_err", 32'(ERR), 32'd0);
    exp_q.delete();
    mstk.delete();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (6) @(negedge CLK);
    check("async_accept", 32'(BUSY), 32'd0);
    check("async_sp", 32'(dut.stk_count_s), 32'd0);
    send_num(8'd6); send_sign(C_SUB); send_num(8'd1); send_end();
    wait_idle("async_recover_drained");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
